// File: rtl/cell_delay_meter.sv
// cell_delay_meter: launches alternating edges into a cell under test and averages
// the synchronised rise and fall response delays in clk cycles.
module cell_delay_meter #(
    parameter int CNT_W       = 16,
    parameter int NAVG_LOG2   = 2,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic             inv,
    output logic             stim,
    input  logic             resp,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] rise_dly,
    output logic [CNT_W-1:0] fall_dly
);
    localparam int NSAMP = 1 << NAVG_LOG2;
    localparam int SUM_W = CNT_W + NAVG_LOG2;
    localparam int SET_W = $clog2(SETTLE_CYC);
    typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, WAIT, DONE} state_t;
    state_t               state_q;
    logic                 stim_q, inv_q, s1_q, s2_q, busy_q, done_q, fail_q;
    logic [CNT_W-1:0]     cnt_q, rise_q, fall_q, meas_d;
    logic [SET_W-1:0]     set_q;
    logic [NAVG_LOG2:0]   tr_q;
    logic [SUM_W-1:0]     rsum_q, fsum_q, rsum_d, fsum_d;
    logic                 hit_d;
    // Two cycles of count are synchroniser latency, not cell delay.
    always_comb begin
        hit_d  = s2_q == (stim_q ^ inv_q);
        meas_d = cnt_q >= CNT_W'(2) ? cnt_q - CNT_W'(2) : '0;
        rsum_d = rsum_q + (s2_q ? SUM_W'(meas_d) : '0);
        fsum_d = fsum_q + (s2_q ? '0 : SUM_W'(meas_d));
    end
    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= IDLE;
            stim_q  <= 1'b0;
            inv_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            set_q   <= '0;
            tr_q    <= '0;
            rsum_q  <= '0;
            fsum_q  <= '0;
        end else begin
            s1_q   <= resp;
            s2_q   <= s1_q;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    rsum_q  <= '0;
                    fsum_q  <= '0;
                    tr_q    <= '0;
                    cnt_q   <= '0;
                    set_q   <= '0;
                    fail_q  <= 1'b0;
                    inv_q   <= inv;
                    busy_q  <= 1'b1;
                    state_q <= SETTLE;
                end
                SETTLE: if (set_q == SET_W'(SETTLE_CYC - 1)) begin
                    set_q <= '0;
                    if (!hit_d) begin
                        fail_q  <= 1'b1;
                        rise_q  <= '1;
                        fall_q  <= '1;
                        stim_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= LAUNCH;
                    end
                end else begin
                    set_q <= set_q + 1'b1;
                end
                LAUNCH: begin
                    stim_q  <= ~stim_q;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (hit_d) begin
                    rsum_q <= rsum_d;
                    fsum_q <= fsum_d;
                    tr_q   <= tr_q + 1'b1;
                    if (tr_q == (NAVG_LOG2+1)'(2*NSAMP - 1)) begin
                        rise_q  <= rsum_d[SUM_W-1:NAVG_LOG2];
                        fall_q  <= fsum_d[SUM_W-1:NAVG_LOG2];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= SETTLE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    fail_q  <= 1'b1;
                    rise_q  <= '1;
                    fall_q  <= '1;
                    stim_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign stim     = stim_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign rise_dly = rise_q;
    assign fall_dly = fall_q;
endmodule
